forth_dbus_responder: RTL

FORTH_DBUS_RESPONDER -- requirements
Module: forth_dbus_responder

---
 rtl/forth_dbus_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/forth_dbus_responder.sv
// Forth CPU data-bus responder: 240x16 RAM, 4-deep UART TX FIFO, LED register, optional cycle counter.
// Define FORTH_DBUS_CYCCNT_EN to build the free-running CYCCNT register at 0xF3.
module forth_dbus_responder #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  daddr,
  input  logic [15:0] ddata_write,
  input  logic        dwrite,
  output logic [15:0] ddata_read,
  output logic        tx,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  localparam logic [9:0] BIT_LAST = 10'(CLKS_PER_BIT - 1);

  localparam logic [7:0] A_TXDATA = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF1;
  localparam logic [7:0] A_LED    = 8'hF2;
  localparam logic [7:0] A_CYCCNT = 8'hF3;

  tx_state_e   state_q, state_d;
  logic [9:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;

  logic [15:0] mem_q [0:239];
  logic [7:0]  fifo_q [0:3];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  led_q;

  logic sel_ram, push_req, push_acc, pop, full, busy, bit_end, ovr_set, ovr_clr;

  assign sel_ram  = (daddr < A_TXDATA);
  assign push_req = dwrite && (daddr == A_TXDATA);
  assign full     = (count_q == 3'd4);
  assign bit_end  = (clk_cnt_q == BIT_LAST);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_acc = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;
  assign ovr_clr  = dwrite && (daddr == A_STATUS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop       = 1'b1;
          state_d   = S_START;
          clk_cnt_d = '0;
          shreg_d   = fifo_q[rd_ptr_q];
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 10'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 10'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            state_d = S_START;
            shreg_d = fifo_q[rd_ptr_q];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state_q != S_IDLE);
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    count_d   = count_q + {2'b00, push_acc} - {2'b00, pop};
    overrun_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      led_q     <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (push_acc) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 2'd1;
      if (dwrite && (daddr == A_LED)) led_q <= ddata_write[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) fifo_q[wr_ptr_q] <= ddata_write[7:0];
  end

  always_ff @(posedge clk) begin
    if (dwrite && sel_ram) mem_q[daddr] <= ddata_write;
  end

`ifdef FORTH_DBUS_CYCCNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        cyc_q <= '0;
    else if (dwrite && (daddr == A_CYCCNT)) cyc_q <= ddata_write;
    else                                 cyc_q <= cyc_q + 16'd1;
  end
`endif

  always_comb begin
    ddata_read = '0;
    if (sel_ram) begin
      ddata_read = mem_q[daddr];
    end else begin
      case (daddr)
        A_STATUS: ddata_read = {10'd0, overrun_q, busy, full, count_q};
        A_LED:    ddata_read = {8'h00, led_q};
`ifdef FORTH_DBUS_CYCCNT_EN
        A_CYCCNT: ddata_read = cyc_q;
`endif
        default:  ddata_read = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule
